// File: rtl/pe_arb_mux.sv
// N-channel priority-select data mux with a registered output word, valid/ready
// handshake, fixed-priority or round-robin arbitration and a per-channel one-cycle ack.
module pe_arb_mux #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  input  logic               mode,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic [IDXW-1:0]    grant,
  output logic [N-1:0]       ack,
  output logic               none
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [N-1:0]    ACK_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [IDXW-1:0]   grant_q, grant_d;
  logic [N-1:0]      ack_q, ack_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]      elig;
  logic [IDXW-1:0]   fp_win;
  logic [IDXW-1:0]   rr_win;
  logic              rr_found;
  logic [IDXW-1:0]   rr_idx;
  logic [IDXW-1:0]   winner;
  logic [WIDTH-1:0]  sel_data;
  logic              load;

  // The channel acked this cycle is masked so a source that drops req one
  // cycle late is never granted twice for the same word.
  assign elig = req & ~ack_q;
  assign none = ~|elig;

  // NOTE: every signal driven in an always_comb gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    fp_win = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i]) fp_win = IDXW'(i);
    end
  end

  // Upward scan from ptr; the wrap is an explicit compare so non-power-of-two
  // N never produces an index beyond N-1.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
      rr_idx = (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
    end
  end

  assign winner = mode ? rr_win : fp_win;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IDXW'(i)) sel_data = din[i*WIDTH +: WIDTH];
    end
  end

  assign load = ((state_q == IDLE) || out_ready) && !none;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    if (load) begin
      state_d = HOLD;
      out_d   = sel_data;
      grant_d = winner;
      ack_d   = ACK_ONE << winner;
      ptr_d   = (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end else if (state_q == HOLD && out_ready) begin
      // Drained with nothing eligible: out and grant keep their last values.
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == HOLD);
  assign grant     = grant_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_pe_arb_mux.sv
// Self-checking bench for pe_arb_mux: an N=8/WIDTH=8 instance and an N=5/WIDTH=16
// instance, checked every cycle against a behavioural model plus directed literals.
module tb_pe_arb_mux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  req_a = '0;
  logic [63:0] din_a;
  logic        mode_a = 1'b0;
  logic        rdy_a = 1'b1;
  logic [7:0]  out_a;
  logic        vld_a;
  logic [2:0]  gnt_a;
  logic [7:0]  ack_a;
  logic        none_a;

  logic [4:0]  req_b = '0;
  logic [79:0] din_b;
  logic        mode_b = 1'b0;
  logic        rdy_b = 1'b1;
  logic [15:0] out_b;
  logic        vld_b;
  logic [2:0]  gnt_b;
  logic [4:0]  ack_b;
  logic        none_b;

  pe_arb_mux #(.N(8), .WIDTH(8), .IDXW(3)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .din(din_a), .mode(mode_a),
    .out_ready(rdy_a), .out(out_a), .out_valid(vld_a), .grant(gnt_a),
    .ack(ack_a), .none(none_a)
  );

  pe_arb_mux #(.N(5), .WIDTH(16), .IDXW(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .din(din_b), .mode(mode_b),
    .out_ready(rdy_b), .out(out_b), .out_valid(vld_b), .grant(gnt_b),
    .ack(ack_b), .none(none_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cmp_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, the word on the output, its channel, the
  // channel acked this cycle (-1 if none) and the round-robin start channel.
  bit          m_vld [2];
  logic [15:0] m_out [2];
  int          m_gnt [2];
  int          m_ack [2];
  int          m_ptr [2];

  function automatic logic [31:0] ackvec(input int a);
    return (a >= 0) ? (32'd1 << a) : 32'd0;
  endfunction

  function automatic int pick(input int n, input logic [31:0] elig, input bit md, input int ptr);
    if (elig == 32'd0) return -1;
    if (!md) begin
      for (int i = n - 1; i >= 0; i--) if (elig[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (elig[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_vld[s] = 1'b0;
      m_out[s] = '0;
      m_gnt[s] = 0;
      m_ack[s] = -1;
      m_ptr[s] = 0;
    end
  endtask

  task automatic model_step(input int s, input int n, input int w, input logic [31:0] rq,
                            input logic [127:0] dn, input bit md, input bit rdy);
    logic [31:0]  elig;
    logic [127:0] t;
    int           win;
    elig = rq & ~ackvec(m_ack[s]);
    win  = pick(n, elig, md, m_ptr[s]);
    if ((!m_vld[s] || rdy) && win >= 0) begin
      t        = dn >> (win * w);
      m_out[s] = (w == 16) ? t[15:0] : {8'h00, t[7:0]};
      m_gnt[s] = win;
      m_ack[s] = win;
      m_vld[s] = 1'b1;
      m_ptr[s] = (win + 1) % n;
    end else begin
      m_ack[s] = -1;
      if (m_vld[s] && rdy) m_vld[s] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0, 8, 8, {24'b0, req_a}, {64'b0, din_a}, mode_a, rdy_a);
        model_step(1, 5, 16, {27'b0, req_b}, {48'b0, din_b}, mode_b, rdy_b);
      end
    end
  end

  // Mid-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en != 0 && rst_n) begin
        check("a_valid", {31'b0, vld_a}, {31'b0, m_vld[0]});
        check("a_out",   {24'b0, out_a}, {24'b0, m_out[0][7:0]});
        check("a_grant", {29'b0, gnt_a}, m_gnt[0]);
        check("a_ack",   {24'b0, ack_a}, ackvec(m_ack[0]));
        check("a_none",  {31'b0, none_a},
              {31'b0, (({24'b0, req_a} & ~ackvec(m_ack[0])) == 32'd0)});
        check("b_valid", {31'b0, vld_b}, {31'b0, m_vld[1]});
        check("b_out",   {16'b0, out_b}, {16'b0, m_out[1]});
        check("b_grant", {29'b0, gnt_b}, m_gnt[1]);
        check("b_ack",   {27'b0, ack_b}, ackvec(m_ack[1]));
        check("b_none",  {31'b0, none_b},
              {31'b0, (({27'b0, req_b} & ~ackvec(m_ack[1])) == 32'd0)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input bit vld, input int gnt,
                          input logic [7:0] o, input logic [7:0] ak);
    check({tag, "_valid"}, {31'b0, vld_a}, {31'b0, vld});
    check({tag, "_grant"}, {29'b0, gnt_a}, gnt);
    check({tag, "_out"},   {24'b0, out_a}, {24'b0, o});
    check({tag, "_ack"},   {24'b0, ack_a}, {24'b0, ak});
  endtask

  int cnt [8];

  initial begin
    // Channel i data: A = 0x11*(i+1), B = 0xB000 + 0x0111*i.
    for (int i = 0; i < 8; i++) din_a[i*8 +: 8] = 8'(8'h11 * (i + 1));
    for (int i = 0; i < 5; i++) din_b[i*16 +: 16] = 16'(16'hB000 + 16'h0111 * i);

    repeat (2) tick();
    expect_a("rst", 1'b0, 0, 8'h00, 8'h00);
    check("rst_none", {31'b0, none_a}, 32'd1);
    rst_n  = 1'b1;
    cmp_en = 1;

    // Fixed priority, each source drops req once acked.
    mode_a = 1'b0; rdy_a = 1'b1; req_a = 8'b1001_0100;
    tick(); expect_a("fp7", 1'b1, 7, 8'h88, 8'h80);
    req_a = 8'b0001_0100;
    tick(); expect_a("fp4", 1'b1, 4, 8'h55, 8'h10);
    req_a = 8'b0000_0100;
    tick(); expect_a("fp2", 1'b1, 2, 8'h33, 8'h04);
    req_a = 8'h00;
    tick(); expect_a("fp_idle", 1'b0, 2, 8'h33, 8'h00);

    // Backpressure: ch3 held while out_ready is low.
    req_a = 8'h08; rdy_a = 1'b0;
    tick(); expect_a("bp_cap3", 1'b1, 3, 8'h44, 8'h08);
    req_a = 8'h81;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_a("bp_hold", 1'b1, 3, 8'h44, 8'h00);
    end
    rdy_a = 1'b1;
    tick(); expect_a("bp_rel7", 1'b1, 7, 8'h88, 8'h80);
    req_a = 8'h01;
    tick(); expect_a("bp_ch0", 1'b1, 0, 8'h11, 8'h01);
    req_a = 8'h00;
    tick(); expect_a("bp_idle", 1'b0, 0, 8'h11, 8'h00);

    // Mode switch: rr grant 2, fixed picks 6, rr resumes from ptr=7 to 3.
    mode_a = 1'b1; req_a = 8'h04;
    tick(); expect_a("ms_rr2", 1'b1, 2, 8'h33, 8'h04);
    req_a = 8'h00; tick();
    mode_a = 1'b0; req_a = 8'b0100_1000;
    tick(); expect_a("ms_fp6", 1'b1, 6, 8'h77, 8'h40);
    req_a = 8'h00; tick();
    mode_a = 1'b1; req_a = 8'b0100_1000;
    tick(); expect_a("ms_rr3", 1'b1, 3, 8'h44, 8'h08);
    req_a = 8'h00; tick();

    // Reset pulsed between edges while a ch5 word is held.
    mode_a = 1'b0; rdy_a = 1'b0; req_a = 8'h20;
    tick(); expect_a("mh_cap5", 1'b1, 5, 8'h66, 8'h20);
    rst_n = 1'b0; req_a = 8'h01;
    #1; expect_a("mh_rst", 1'b0, 0, 8'h00, 8'h00);
    #1; rst_n = 1'b1;
    tick(); expect_a("mh_post0", 1'b1, 0, 8'h11, 8'h01);
    rdy_a = 1'b1; req_a = 8'h00;
    tick(); expect_a("mh_idle", 1'b0, 0, 8'h11, 8'h00);

    // Round-robin fairness from reset on both instances.
    rst_n = 1'b0;
    mode_a = 1'b1; req_a = 8'hFF; rdy_a = 1'b1;
    mode_b = 1'b1; req_b = 5'h1F; rdy_b = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      expect_a("rr", 1'b1, i % 8, 8'(8'h11 * ((i % 8) + 1)), 8'(8'h01 << (i % 8)));
      if (i < 8) cnt[gnt_a]++;
      check("b_rr_grant", {29'b0, gnt_b}, i % 5);
      check("b_rr_out", {16'b0, out_b}, 32'(16'hB000 + 16'h0111 * (i % 5)));
      check("b_grant_range", {31'b0, (gnt_b < 3'd5)}, 32'd1);
    end
    for (int i = 0; i < 8; i++) check("rr_fair", cnt[i], 1);

    req_a = 8'h00; req_b = 5'h00;
    repeat (3) tick();
    check("end_idle_a", {31'b0, vld_a}, 32'd0);
    check("end_idle_b", {31'b0, vld_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
